// File: rtl/facto_pkg.sv
// facto_pkg: items shared by the factorial accelerator master and slave decoder.
//   - Register offsets within the accelerator window
//   - Control bit positions inside OPSTART / OPCLEAR
//   - Master sequencer state encoding
package facto_pkg;

  localparam logic [15:0] REG_OPSTART  = 16'h0000;
  localparam logic [15:0] REG_OPCLEAR  = 16'h0008;
  localparam logic [15:0] REG_OPDONE   = 16'h0010;
  localparam logic [15:0] REG_INTREN   = 16'h0018;
  localparam logic [15:0] REG_OPERAND  = 16'h0020;
  localparam logic [15:0] REG_RESULT_H = 16'h0028;
  localparam logic [15:0] REG_RESULT_L = 16'h0030;

  localparam logic [5:0] OPSTART_BIT = 6'd0;
  localparam logic [5:0] OPCLEAR_BIT = 6'd0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_IEN,
    ST_W_OPND,
    ST_W_START,
    ST_WAIT,
    ST_POLL,
    ST_R_H,
    ST_R_L,
    ST_W_CLR,
    ST_W_UNCLR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/facto_master.sv
// facto_master: bus-master sequencer for the factorial accelerator.
// Takes one 64-bit operand per job over a valid/ready interface, programs
// the accelerator (INTREN, OPERAND, OPSTART), waits for completion by
// interrupt or OPDONE polling (with timeout), reads the 128-bit result,
// clears the core and presents the result until consumed.
// Ports:
//   clk, reset_n            clock; synchronous reset, active HIGH
//   cmd_valid/ready/operand job request
//   res_valid/ready/h/l/err result handshake, 128-bit result, timeout flag
//   busy                    high outside IDLE
//   m_sel/wr/addr/dout/din  one-cycle accesses to the slave register port
//   interrupt               slave completion interrupt
module facto_master
  import facto_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter bit          USE_INTR  = 1'b1,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_operand,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_h,
  output logic [63:0] res_l,
  output logic        res_err,
  output logic        busy,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        interrupt
);

  state_e      state_q, state_d;
  logic [63:0] opnd_q, opnd_d;
  logic [63:0] res_h_q, res_h_d;
  logic [63:0] res_l_q, res_l_d;
  logic        err_q, err_d;
  logic [31:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]  gap_q, gap_d;
  logic        timed_out;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= ST_IDLE;
      opnd_q  <= '0;
      res_h_q <= '0;
      res_l_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_h_q <= res_h_d;
      res_l_q <= res_l_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    res_h_d   = res_h_q;
    res_l_d   = res_l_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    m_sel     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    // Saturating wait counter; the job aborts on the cycle it reaches TIMEOUT.
    tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
    timed_out = (tmo_inc >= TIMEOUT);

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          opnd_d  = cmd_operand;
          err_d   = 1'b0;
          res_h_d = '0;
          res_l_d = '0;
          state_d = ST_W_IEN;
        end
      end
      ST_W_IEN: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = BASE_ADDR + REG_INTREN;
        m_dout  = {63'd0, USE_INTR};
        state_d = ST_W_OPND;
      end
      ST_W_OPND: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = BASE_ADDR + REG_OPERAND;
        m_dout  = opnd_q;
        state_d = ST_W_START;
      end
      ST_W_START: begin
        m_sel               = 1'b1;
        m_wr                = 1'b1;
        m_addr              = BASE_ADDR + REG_OPSTART;
        m_dout[OPSTART_BIT] = 1'b1;
        tmo_d               = '0;
        gap_d               = '0;
        state_d             = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_inc;
        // Completion seen in the same cycle as the timeout still wins.
        if (USE_INTR && interrupt) begin
          state_d = ST_R_H;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_W_CLR;
        end else if (!USE_INTR) begin
          if ({24'd0, gap_q} + 32'd1 >= POLL_GAP) begin
            gap_d   = '0;
            state_d = ST_POLL;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
      end
      ST_POLL: begin
        m_sel  = 1'b1;
        m_addr = BASE_ADDR + REG_OPDONE;
        tmo_d  = tmo_inc;
        gap_d  = '0;
        if (m_din[0]) begin
          state_d = ST_R_H;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_W_CLR;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_R_H: begin
        m_sel   = 1'b1;
        m_addr  = BASE_ADDR + REG_RESULT_H;
        res_h_d = m_din;
        state_d = ST_R_L;
      end
      ST_R_L: begin
        m_sel   = 1'b1;
        m_addr  = BASE_ADDR + REG_RESULT_L;
        res_l_d = m_din;
        state_d = ST_W_CLR;
      end
      ST_W_CLR: begin
        m_sel               = 1'b1;
        m_wr                = 1'b1;
        m_addr              = BASE_ADDR + REG_OPCLEAR;
        m_dout[OPCLEAR_BIT] = 1'b1;
        state_d             = ST_W_UNCLR;
      end
      ST_W_UNCLR: begin
        // Releasing the clear lets the core accept the next start.
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = BASE_ADDR + REG_OPCLEAR;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign res_h   = res_h_q;
  assign res_l   = res_l_q;
  assign res_err = (state_q == ST_DONE) && err_q;

endmodule
